multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle main controller that sequences the shared ALU, register file, PC and unified memory port.
//  It decodes opcode into a state sequence and drives alu_op (3b, consumed by alu_decoder with funct3) and all mux selects.
//  It also handshakes with memory and keeps a retired-instruction counter.
// PARAMETERS
//  INSTRET_W  32  width of retired-instruction counter (wraps modulo 2^INSTRET_W)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous, active-low reset
//  opcode      in   7   instr[6:0] from IR (valid from DECODE onward)
//  br_taken    in   1   branch comparator result, valid in BRANCH
//  mem_ready   in   1   memory completes request this cycle; ignored when mem_req=0
//  mem_req     out  1   memory request, held until mem_ready
//  mem_we      out  1   write qualifier for mem_req
//  ir_write    out  1   load IR and oldPC
//  pc_write    out  1   update PC
//  pc_src      out  2   00 ALU result, 01 ALUout reg, 10 ALU result & ~1 (jalr)
//  alu_src_a   out  2   00 PC, 01 oldPC, 10 rs1, 11 zero
//  alu_src_b   out  2   00 rs2, 01 imm, 10 const 4
//  alu_op      out  3   000 none, 001 branch cmp, 010 add, 011 I-ALU, 100 R-ALU
//  reg_write   out  1   register-file write enable
//  result_src  out  2   00 ALUout, 01 mem rdata, 10 PC (= oldPC+4)
//  instret     out  INSTRET_W  retired instruction count
//  illegal     out  1   sticky illegal-opcode flag
// BEHAVIOUR
//  - Moore FSM; outputs decode from state (plus mem_ready/br_taken where noted). Unlisted outputs are 0.
//  - Reset (async, immediate): state=IDLE, instret=0, illegal=0. All outputs are 0 while in IDLE.
//  - IDLE: -> FETCH unconditionally. This gives one clean cycle after rst_n rises.
//  - FETCH: mem_req=1, src_a=00, src_b=10, alu_op=010.
//    On mem_ready: ir_write=1, pc_write=1, pc_src=00, then -> DECODE. Otherwise stay.
//  - DECODE: src_a=01, src_b=01, alu_op=010 (ALUout<=oldPC+imm). Next state by opcode:
//    0110011->EXEC_R; 0010011->EXEC_I; 0000011/0100011->MEMADDR; 1100011->BRANCH;
//    1101111->JAL; 1100111->JALR; 0110111->LUI; 0010111->ALUWB (auipc); else -> see CONFIGURATION.
//  - EXEC_R: src_a=10, src_b=00, alu_op=100 -> ALUWB.
//  - EXEC_I: src_a=10, src_b=01, alu_op=011 -> ALUWB.
//  - LUI: src_a=11, src_b=01, alu_op=010 -> ALUWB.
//  - MEMADDR: src_a=10, src_b=01, alu_op=010. -> MEMRD if opcode[5]=0, else -> MEMWR.
//  - MEMRD: mem_req=1; on mem_ready -> MEMWB. MEMWB: reg_write=1, result_src=01 -> FETCH.
//  - MEMWR: mem_req=1, mem_we=1; on mem_ready -> FETCH.
//  - ALUWB: reg_write=1, result_src=00 -> FETCH.
//  - BRANCH: src_a=10, src_b=00, alu_op=001, pc_src=01, pc_write=br_taken -> FETCH.
//  - JAL: reg_write=1, result_src=10, pc_write=1, pc_src=01 -> FETCH.
//  - JALR: src_a=10, src_b=01, alu_op=010, pc_src=10, pc_write=1, reg_write=1, result_src=10 -> FETCH.
//  - instret increments by 1 on every edge where the state enters FETCH from any state other than IDLE.
//    It wraps silently at all-ones.
//  - Wait states are unbounded. mem_req never drops before mem_ready.
//  - rst_n low mid-request: mem_req/mem_we drop asynchronously; the transaction is abandoned.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    Unknown opcode in DECODE -> TRAP; illegal<=1 on entry.
//    TRAP is absorbing: all outputs 0, instret frozen. Exit only via reset.
//  ILLEGAL_TRAP_EN undefined:
//    Unknown opcode in DECODE -> FETCH (executes as NOP); instret increments.
//    The illegal port is present and tied 0.
// TESTING
//  1 Reset, opcode=0110011, mem_ready on 2nd FETCH cycle.
//    -> IDLE,FETCH,FETCH,DECODE,EXEC_R(alu_op=100),ALUWB(reg_write=1); instret=1.
//  2 Load opcode=0000011, mem_ready low 3 cycles in MEMRD.
//    -> mem_req=1 for exactly 4 MEMRD cycles; MEMWB result_src=01; instret+1.
//  3 Branch 1100011: br_taken=1 -> pc_write=1, pc_src=01 in BRANCH.
//    Repeat with br_taken=0 -> pc_write=0; both return to FETCH.
//  4 JALR 1100111 -> single cycle with pc_write=1, pc_src=10, reg_write=1, result_src=10, alu_op=010.
//  5 Opcode 0000000, macro on -> illegal=1, mem_req=0 for 20 cycles, instret unchanged.
//    Macro off -> next state FETCH, instret+1, illegal=0.
//  6 rst_n low while in MEMWR with mem_ready=0 -> mem_req=mem_we=0 the same cycle, instret=0.
//    Restart runs IDLE->FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore controller sequencing ALU, register file, PC and unified memory port.
// Latency: outputs decoded from state. FETCH/MEMRD/MEMWR wait on mem_ready; every other state lasts 1 cycle.
// Backpressure: mem_req is held until mem_ready. Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they run as NOPs.
module multicycle_ctrl_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 br_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_MEMADDR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    result_src = 2'b00;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUout captures oldPC+imm here so BRANCH/JAL can use it as target
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        case (opcode)
          OP_R:               state_nx = S_EXEC_R;
          OP_I:               state_nx = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nx = S_MEMADDR;
          OP_BR:              state_nx = S_BRANCH;
          OP_JAL:             state_nx = S_JAL;
          OP_JALR:            state_nx = S_JALR;
          OP_LUI:             state_nx = S_LUI;
          OP_AUIPC:           state_nx = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
          default:            state_nx = S_TRAP;
`else
          default:            state_nx = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b100;
        state_nx  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        state_nx  = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        state_nx  = S_ALUWB;
      end
      S_MEMADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        state_nx  = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        pc_write  = br_taken;
        state_nx  = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        state_nx   = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 3'b010;
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        state_nx   = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_IDLE;
    endcase
  end

  // FETCH->FETCH wait cycles and the post-reset IDLE->FETCH are not retirements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret <= '0;
    else if (state_nx == S_FETCH && state != S_FETCH && state != S_IDLE)
      instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   illegal_q <= 1'b0;
    else if (state == S_DECODE && state_nx == S_TRAP) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
